// File: rtl/pwm_capture.sv
// pwm_capture: measures the period and high time of a PWM waveform in clk
// cycles and flags a stuck (constant-level) input by timeout.
//
// Ports:
//   clk          clock
//   rstn         synchronous active-low reset
//   en           capture enable; 0 forces IDLE and clears counters/stuck
//   pwm_in       asynchronous PWM input
//   period_out   last complete period, zero-extended from CNT_W to 32 bits
//   high_out     last complete high time, zero-extended from CNT_W to 32 bits
//   meas_valid   one-cycle pulse when period_out/high_out update
//   stuck        no rising edge seen for TIMEOUT cycles
//   stuck_level  synchronised input level when stuck was set
//
// Parameters:
//   CNT_W        measurement counter width (matches the PWM top/compare field)
//   SYNC_STAGES  synchroniser depth on pwm_in, minimum 2
//   TIMEOUT      cycles without a rise before stuck; must be < 2^CNT_W-1
module pwm_capture #(
   parameter int unsigned      CNT_W       = 27,
   parameter int unsigned      SYNC_STAGES = 2,
   parameter logic [CNT_W-1:0] TIMEOUT     = 27'h7FFFFFE
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        en,
   input  logic        pwm_in,
   output logic [31:0] period_out,
   output logic [31:0] high_out,
   output logic        meas_valid,
   output logic        stuck,
   output logic        stuck_level
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      STUCK = 2'd2
   } state_e;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic [CNT_W-1:0]       pcnt_q, pcnt_d;
   logic [CNT_W-1:0]       hcnt_q, hcnt_d;
   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       period_q, period_d;
   logic [CNT_W-1:0]       high_q, high_d;
   logic                   valid_q, valid_d;
   logic                   stuck_q, stuck_d;
   logic                   level_q, level_d;

   logic                   s_c;
   logic                   rise_c;

   // Counters saturate at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   // Synchronised level and its rising edge.
   assign s_c    = sync_q[SYNC_STAGES-1];
   assign rise_c = s_c & ~prev_q;

   // Next-state, counter and result logic.
   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], pwm_in};
      prev_d   = s_c;
      state_d  = state_q;
      pcnt_d   = pcnt_q;
      hcnt_d   = hcnt_q;
      period_d = period_q;
      high_d   = high_q;
      valid_d  = 1'b0;
      stuck_d  = stuck_q;
      level_d  = level_q;

      if (!en) begin
         state_d = IDLE;
         pcnt_d  = '0;
         hcnt_d  = '0;
         stuck_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               pcnt_d = '0;
               hcnt_d = '0;
               if (rise_c) begin
                  state_d = ARMED;
                  pcnt_d  = CNT_ONE;
                  hcnt_d  = CNT_ONE;
               end
            end

            ARMED: begin
               // A rise on the timeout cycle still counts as a valid period.
               if (rise_c) begin
                  period_d = pcnt_q;
                  high_d   = hcnt_q;
                  valid_d  = 1'b1;
                  pcnt_d   = CNT_ONE;
                  hcnt_d   = CNT_ONE;
               end else if (pcnt_q >= TIMEOUT) begin
                  state_d = STUCK;
                  stuck_d = 1'b1;
                  level_d = s_c;
               end else begin
                  pcnt_d = sat_inc(pcnt_q);
                  // s stays high from a rise until its fall, and the next high
                  // is always a new rise, so s=1 alone means "still in the high
                  // phase"; hcnt therefore freezes at the fall.
                  if (s_c) begin
                     hcnt_d = sat_inc(hcnt_q);
                  end
               end
            end

            STUCK: begin
               // Recovery restarts counting; the first period is not reported.
               if (rise_c) begin
                  state_d = ARMED;
                  stuck_d = 1'b0;
                  pcnt_d  = CNT_ONE;
                  hcnt_d  = CNT_ONE;
               end
            end

            default: begin
               state_d = IDLE;
               pcnt_d  = '0;
               hcnt_d  = '0;
            end
         endcase
      end
   end

   // State and data registers.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         sync_q   <= '0;
         prev_q   <= 1'b0;
         pcnt_q   <= '0;
         hcnt_q   <= '0;
         state_q  <= IDLE;
         period_q <= '0;
         high_q   <= '0;
         valid_q  <= 1'b0;
         stuck_q  <= 1'b0;
         level_q  <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         prev_q   <= prev_d;
         pcnt_q   <= pcnt_d;
         hcnt_q   <= hcnt_d;
         state_q  <= state_d;
         period_q <= period_d;
         high_q   <= high_d;
         valid_q  <= valid_d;
         stuck_q  <= stuck_d;
         level_q  <= level_d;
      end
   end

   // Zero-extended results.
   assign period_out  = 32'(period_q);
   assign high_out    = 32'(high_q);
   assign meas_valid  = valid_q;
   assign stuck       = stuck_q;
   assign stuck_level = level_q;

endmodule
